// File: rtl/bus_master_arb_pkg.sv
// Shared bus types and round-robin helpers for the bus master arbiter.
package bus_master_arb_pkg;

  localparam int unsigned ARB_MAX_MASTERS = 8;
  localparam int unsigned ARB_IDX_W       = $clog2(ARB_MAX_MASTERS);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic        req;
  } m2s_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ack;
  } s2m_s;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Searches from last+1 with mod-8 wrap; unused upper request bits must be zero, which makes
  // the result identical to a mod-N search for any N <= ARB_MAX_MASTERS.
  function automatic logic [ARB_MAX_MASTERS-1:0] rr_pick(
    input logic [ARB_MAX_MASTERS-1:0] req,
    input logic [ARB_IDX_W-1:0]       last
  );
    logic [ARB_MAX_MASTERS-1:0] gnt;
    logic [ARB_IDX_W-1:0]       idx;
    gnt = '0;
    for (int unsigned off = 1; off <= ARB_MAX_MASTERS; off++) begin
      idx = last + ARB_IDX_W'(off);
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/bus_master_arb_rr_arbiter.sv
// Combinational round-robin pick: one-hot winner after last_i, plus a valid flag.
module rr_arbiter
  import bus_master_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         gnt_o,
  output logic                 valid_o
);

  logic [ARB_MAX_MASTERS-1:0] req_pad;
  logic [ARB_MAX_MASTERS-1:0] gnt_pad;
  logic [ARB_IDX_W-1:0]       last_pad;
  logic                       unused_gnt;

  always_comb begin
    req_pad                     = '0;
    req_pad[N-1:0]              = req_i;
    last_pad                    = '0;
    last_pad[$clog2(N)-1:0]     = last_i;
    gnt_pad                     = rr_pick(req_pad, last_pad);
  end

  assign gnt_o      = gnt_pad[N-1:0];
  assign valid_o    = |req_i;
  // Bits above N are always zero since their requests are tied off.
  assign unused_gnt = ^gnt_pad;

endmodule

// File: rtl/bus_master_arb.sv
// Round-robin arbiter sharing one bus master port among numMasters requesters,
// holding the grant for a full req->ack transaction with a hung-slave timeout.
module bus_master_arb
  import bus_master_arb_pkg::*;
#(
  parameter int unsigned numMasters = 2,
  parameter int unsigned timeout    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  m2s_s [numMasters-1:0]   bus_master_out_i,
  output s2m_s [numMasters-1:0]   bus_master_in_o,
  output m2s_s                    bus_arb_out_o,
  input  s2m_s                    bus_arb_in_i,
  output logic [numMasters-1:0]   grant_o,
  output logic                    bus_err_o
);

  localparam int unsigned IdxW = $clog2(numMasters);
  localparam int unsigned CntW = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(timeout - 1);

  arb_state_e              state_q, state_d;
  logic [numMasters-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]         gidx_q, gidx_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic [numMasters-1:0]   req_vec;
  logic [numMasters-1:0]   pick_gnt;
  logic                    pick_valid;
  logic [IdxW-1:0]         pick_idx;
  m2s_s                    cur_req;
  logic                    timeout_hit;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < numMasters; i++) begin
      req_vec[i] = bus_master_out_i[i].req;
    end
  end

  rr_arbiter #(
    .N (numMasters)
  ) u_rr_arbiter (
    .req_i   (req_vec),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < numMasters; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = IdxW'(i);
      end
    end
  end

  assign cur_req     = bus_master_out_i[gidx_q];
  assign timeout_hit = (timeout != 0) && (cnt_q == TimeoutLast);
  assign grant_o     = grant_q;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    gidx_d          = gidx_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    bus_arb_out_o   = '0;
    bus_master_in_o = '0;
    bus_err_o       = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!cur_req.req) begin
          // Withdrawn request: nothing downstream, nothing forwarded back.
          bus_err_o = 1'b1;
          last_d    = gidx_q;
          grant_d   = '0;
          state_d   = ARB_IDLE;
        end else begin
          bus_arb_out_o = cur_req;
          if (bus_arb_in_i.ack) begin
            bus_master_in_o[gidx_q] = bus_arb_in_i;
            last_d                  = gidx_q;
            grant_d                 = '0;
            state_d                 = ARB_IDLE;
          end else if (timeout_hit) begin
            bus_arb_out_o.req           = 1'b0;
            bus_master_in_o[gidx_q].ack = 1'b1;
            bus_err_o                   = 1'b1;
            last_d                      = gidx_q;
            grant_d                     = '0;
            state_d                     = ARB_IDLE;
          end else begin
            bus_master_in_o[gidx_q] = bus_arb_in_i;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IdxW'(numMasters - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_master_arb.sv
// Directed bench for bus_master_arb with four masters and an 8-cycle timeout.
module tb_bus_master_arb;
  import bus_master_arb_pkg::*;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic       clk;
  logic       rst;
  m2s_s [3:0] mo;
  s2m_s [3:0] mi;
  m2s_s       arb_o;
  s2m_s       arb_i;
  logic [3:0] grant;
  logic       err;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        ack;
    logic [31:0] rdata;
    logic [3:0]  exp_grant;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mack;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  bus_master_arb #(
    .numMasters (4),
    .timeout    (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus_master_out_i (mo),
    .bus_master_in_o  (mi),
    .bus_arb_out_o    (arb_o),
    .bus_arb_in_i     (arb_i),
    .grant_o          (grant),
    .bus_err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    for (int i = 0; i < 4; i++) mo[i].req = r[i];
  endtask

  function automatic logic [3:0] mack();
    logic [3:0] a;
    for (int i = 0; i < 4; i++) a[i] = mi[i].ack;
    return a;
  endfunction

  function automatic logic [31:0] mrdata_or();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = r | mi[i].rdata;
    return r;
  endfunction

  task automatic add(input logic r, input logic [3:0] q, input logic a, input logic [31:0] d,
                     input logic [3:0] eg, input logic er, input logic [31:0] ea,
                     input logic [3:0] em, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a; v.rdata = d;
    v.exp_grant = eg; v.exp_req = er; v.exp_addr = ea;
    v.exp_mack = em; v.exp_rdata = ed; v.exp_err = ee;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    set_req(4'b0000);
    arb_i = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    int         gcnt[4];
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    arb_i  = '0;
    for (int i = 0; i < 4; i++) begin
      mo[i].addr  = 32'h1000 * (i + 1);
      mo[i].wdata = 32'hA000_0000 + i;
      mo[i].sel   = 4'hF;
      mo[i].we    = i[0];
      mo[i].req   = 1'b0;
      gcnt[i]     = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset grant", 32'(grant), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset arb_out", 32'(arb_o.req) | arb_o.addr, 32'h0);
    check("reset m_ack", 32'(mack()), 32'h0);

    // Single request, contention, then withdrawn request; one row per cycle.
    add(0, 4'b0001, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(0, 4'b0001, 0, 0,            4'b0001, 1, A0, 4'b0000, 0,            0);
    add(0, 4'b0001, 0, 0,            4'b0001, 1, A0, 4'b0000, 0,            0);
    add(0, 4'b0001, 1, 32'hDEAD0003, 4'b0001, 1, A0, 4'b0001, 32'hDEAD0003, 0);
    add(0, 4'b0000, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(1, 4'b0000, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(0, 4'b0011, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(0, 4'b0011, 1, 32'h0000_0007, 4'b0001, 1, A0, 4'b0001, 32'h0000_0007, 0);
    add(0, 4'b0010, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(0, 4'b0011, 0, 0,            4'b0010, 1, A1, 4'b0000, 0,            0);
    add(0, 4'b0011, 1, 32'h0000_0010, 4'b0010, 1, A1, 4'b0010, 32'h0000_0010, 0);
    add(0, 4'b0001, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(0, 4'b0001, 1, 32'h0000_0012, 4'b0001, 1, A0, 4'b0001, 32'h0000_0012, 0);
    add(0, 4'b0000, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(0, 4'b0010, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);
    add(0, 4'b0010, 0, 0,            4'b0010, 1, A1, 4'b0000, 0,            0);
    add(0, 4'b0000, 1, 32'h0000_0016, 4'b0010, 0, 0,  4'b0000, 0,            1);
    add(0, 4'b0000, 0, 0,            4'b0000, 0, 0,  4'b0000, 0,            0);

    for (int k = 0; k < vq.size(); k++) begin
      cyc();
      rst         = vq[k].rst;
      set_req(vq[k].req);
      arb_i.ack   = vq[k].ack;
      arb_i.rdata = vq[k].rdata;
      @(negedge clk);
      check($sformatf("vec%0d grant", k), 32'(grant), 32'(vq[k].exp_grant));
      check($sformatf("vec%0d arb_req", k), 32'(arb_o.req), 32'(vq[k].exp_req));
      check($sformatf("vec%0d arb_addr", k), arb_o.addr, vq[k].exp_addr);
      check($sformatf("vec%0d m_ack", k), 32'(mack()), 32'(vq[k].exp_mack));
      check($sformatf("vec%0d m_rdata", k), mrdata_or(), vq[k].exp_rdata);
      check($sformatf("vec%0d err", k), 32'(err), 32'(vq[k].exp_err));
    end

    // Saturation: all masters request, slave acks in the first BUSY cycle.
    do_reset();
    for (int k = 0; k < 100; k++) begin
      cyc();
      set_req(4'b1111);
      arb_i = '0;
      @(negedge clk);
      check($sformatf("sat%0d idle grant", k), 32'(grant), 32'h0);
      cyc();
      arb_i.ack   = 1'b1;
      arb_i.rdata = 32'(k);
      exp_g       = 4'b0001 << (k % 4);
      @(negedge clk);
      check($sformatf("sat%0d grant", k), 32'(grant), 32'(exp_g));
      check($sformatf("sat%0d m_ack", k), 32'(mack()), 32'(exp_g));
      for (int i = 0; i < 4; i++) if (mi[i].ack) gcnt[i]++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("sat count m%0d", i), 32'(gcnt[i]), 32'd25);

    // Timeout: slave never acks m0.
    do_reset();
    cyc();
    set_req(4'b0001);
    arb_i.ack   = 1'b0;
    arb_i.rdata = 32'h0000_0BAD;
    @(negedge clk);
    check("to idle grant", 32'(grant), 32'h0);
    for (int b = 1; b <= 8; b++) begin
      cyc();
      @(negedge clk);
      check($sformatf("to busy%0d grant", b), 32'(grant), 32'h1);
      if (b < 8) begin
        check($sformatf("to busy%0d err", b), 32'(err), 32'h0);
        check($sformatf("to busy%0d arb_req", b), 32'(arb_o.req), 32'h1);
        check($sformatf("to busy%0d m_ack", b), 32'(mack()), 32'h0);
      end else begin
        check("to hit err", 32'(err), 32'h1);
        check("to hit arb_req", 32'(arb_o.req), 32'h0);
        check("to hit m_ack", 32'(mack()), 32'h1);
        check("to hit m0 rdata", mi[0].rdata, 32'h0);
      end
    end
    cyc();
    set_req(4'b0010);
    arb_i = '0;
    @(negedge clk);
    check("to after grant", 32'(grant), 32'h0);
    check("to after err", 32'(err), 32'h0);
    cyc();
    arb_i.ack   = 1'b1;
    arb_i.rdata = 32'h0000_0055;
    @(negedge clk);
    check("to next grant", 32'(grant), 32'h2);
    check("to next m_ack", 32'(mack()), 32'h2);
    check("to next m1 rdata", mi[1].rdata, 32'h0000_0055);
    check("to next err", 32'(err), 32'h0);

    // Ack lands on the same cycle the timeout would fire: ack wins.
    cyc();
    set_req(4'b0100);
    arb_i = '0;
    @(negedge clk);
    for (int b = 1; b <= 8; b++) begin
      cyc();
      if (b == 8) begin
        arb_i.ack   = 1'b1;
        arb_i.rdata = 32'h0000_0077;
      end
      @(negedge clk);
    end
    check("ackwin grant", 32'(grant), 32'h4);
    check("ackwin err", 32'(err), 32'h0);
    check("ackwin m_ack", 32'(mack()), 32'h4);
    check("ackwin m2 rdata", mi[2].rdata, 32'h0000_0077);
    cyc();
    set_req(4'b0000);
    arb_i = '0;
    @(negedge clk);
    check("ackwin after grant", 32'(grant), 32'h0);
    check("ackwin after err", 32'(err), 32'h0);

    // Reset while m1 holds the grant.
    do_reset();
    cyc();
    set_req(4'b0010);
    @(negedge clk);
    cyc();
    @(negedge clk);
    check("rstbusy grant", 32'(grant), 32'h2);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    set_req(4'b0011);
    @(negedge clk);
    check("rstbusy post grant", 32'(grant), 32'h0);
    check("rstbusy post arb", 32'(arb_o.req) | arb_o.addr, 32'h0);
    check("rstbusy post m_ack", 32'(mack()), 32'h0);
    check("rstbusy post err", 32'(err), 32'h0);
    cyc();
    arb_i.ack = 1'b1;
    @(negedge clk);
    check("rstbusy first grant", 32'(grant), 32'h1);
    check("rstbusy first m_ack", 32'(mack()), 32'h1);
    cyc();
    set_req(4'b0010);
    arb_i.ack = 1'b0;
    @(negedge clk);
    cyc();
    arb_i.ack = 1'b1;
    @(negedge clk);
    check("rstbusy second grant", 32'(grant), 32'h2);
    check("rstbusy second m_ack", 32'(mack()), 32'h2);
    cyc();
    set_req(4'b0000);
    arb_i = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
